// File: rtl/pwm_peripheral.sv
// 16-output PWM stage: each output is forced low, static high, or driven by one
// shared 8-bit PWM waveform whose duty is latched only at period boundaries.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_wrap
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;
    logic [7:0]    r_pwm_cnt;
    logic [7:0]    r_duty_shadow;
    logic [15:0]   r_out;
    logic          r_pwm_wrap;

    logic          w_tick;
    logic          w_boundary;
    logic          w_pwm_sig;
    logic [15:0]   w_en_out;
    logic [15:0]   w_en_pwm;
    logic [15:0]   w_out_next;

    assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign w_tick     = (r_pre_cnt == PRE_LAST);
    assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

    // 0xFF is a true 100 % (never low), not 255/256.
    assign w_pwm_sig  = (r_duty_shadow == 8'hFF) || (r_pwm_cnt < r_duty_shadow);

    // Disabled bits are low; enabled non-PWM bits are static high.
    assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_sig}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'h00;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // The shadow changes on the same edge the counter returns to 0, so a
    // period always runs with a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= 8'h00;
        end else if (w_boundary) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_wrap <= 1'b0;
            r_out      <= 16'h0000;
        end else begin
            r_pwm_wrap <= w_boundary;
            r_out      <= w_out_next;
        end
    end

    assign out      = r_out;
    assign pwm_wrap = r_pwm_wrap;

endmodule
